// File: rtl/elastic_stage_reg.sv
// Purpose : valid/ready pipeline stage register with flush, optional 2-entry skid and stall counter.
// Latency : one cycle from input acceptance to out_valid when the stage is empty.
// Backpr. : SKID_EN=1 registers in_ready (deasserts only when both entries are held);
//           SKID_EN=0 passes out_ready through to in_ready combinationally.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   flush           drops every held entry; the beat offered in the same cycle is lost
//   in_valid/ready  upstream handshake, in_data is the opaque payload
//   out_valid/ready downstream handshake, out_data is RESET_VAL whenever out_valid=0
//   stall_cnt       saturating count of cycles with out_valid && !out_ready (reset-only clear)
module elastic_stage_reg #(
  parameter int unsigned       DATA_W    = 103,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter bit                SKID_EN   = 1'b1,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              in_fire;
  logic              out_fire;
  logic              main_vld;
  logic [DATA_W-1:0] main_dat;

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign out_valid = main_vld;
  // main_dat keeps stale payload after a pop, so mask it while empty.
  assign out_data  = main_vld ? main_dat : RESET_VAL;

  if (SKID_EN) begin : g_skid
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]        st_q;
    logic [1:0]        st_n;
    logic              in_rdy_q;
    logic [DATA_W-1:0] skid_dat;

    assign main_vld = (st_q != ST_EMPTY);
    assign in_ready = in_rdy_q;

    always_comb begin
      st_n = st_q;
      case (st_q)
        ST_EMPTY: if (in_fire) st_n = ST_ONE;
        ST_ONE: begin
          if (in_fire && !out_fire)      st_n = ST_FULL;
          else if (out_fire && !in_fire) st_n = ST_EMPTY;
        end
        ST_FULL:  if (out_fire) st_n = ST_ONE;
        default:  st_n = ST_EMPTY;
      endcase
    end

    // in_ready is the registered "next state is not FULL", so downstream
    // out_ready never reaches upstream in the same cycle.
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        st_q     <= ST_EMPTY;
        in_rdy_q <= 1'b1;
      end else begin
        st_q     <= st_n;
        in_rdy_q <= (st_n != ST_FULL);
      end
    end

    always_ff @(posedge clk) begin
      if (rst || flush) begin
        main_dat <= RESET_VAL;
        skid_dat <= RESET_VAL;
      end else begin
        case (st_q)
          ST_EMPTY: if (in_fire) main_dat <= in_data;
          ST_ONE: begin
            if (in_fire && out_fire) main_dat <= in_data;
            else if (in_fire)        skid_dat <= in_data;
          end
          ST_FULL: begin
            if (out_fire) begin
              main_dat <= skid_dat;
              skid_dat <= RESET_VAL;
            end
          end
          default: ;
        endcase
      end
    end
  end else begin : g_single
    assign in_ready = !main_vld || out_ready;

    // A simultaneous push and pop simply overwrites the entry: no bubble.
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        main_vld <= 1'b0;
        main_dat <= RESET_VAL;
      end else if (in_fire) begin
        main_vld <= 1'b1;
        main_dat <= in_data;
      end else if (out_fire) begin
        main_vld <= 1'b0;
      end
    end
  end

  // Counts on the flush edge too: the stall is judged on pre-flush outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
